// File: rtl/renode_uart_bridge_mc.sv
// Multi-channel UART character bridge: per-channel down/up FIFOs plus a round-robin upstream merger.
// Optional statistics counters are compiled in when RENODE_UART_BRIDGE_STATS_EN is defined.
module renode_uart_bridge_mc #(
    parameter int ChannelCount = 4,
    parameter int DataWidth    = 8,
    parameter int FifoDepth    = 8,
    localparam int ChanW       = (ChannelCount > 1) ? $clog2(ChannelCount) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              host_tx_valid,
    output logic                              host_tx_ready,
    input  logic [ChanW-1:0]                  host_tx_channel,
    input  logic [DataWidth-1:0]              host_tx_data,
    output logic [ChannelCount-1:0]           dut_rx_valid,
    input  logic [ChannelCount-1:0]           dut_rx_ready,
    output logic [ChannelCount*DataWidth-1:0] dut_rx_data,
    input  logic [ChannelCount-1:0]           dut_tx_valid,
    output logic [ChannelCount-1:0]           dut_tx_ready,
    input  logic [ChannelCount*DataWidth-1:0] dut_tx_data,
    output logic                              host_rx_valid,
    input  logic                              host_rx_ready,
    output logic [ChanW-1:0]                  host_rx_channel,
    output logic [DataWidth-1:0]              host_rx_data,
    output logic                              bad_channel
`ifdef RENODE_UART_BRIDGE_STATS_EN
   ,output logic [ChannelCount*16-1:0]        stat_down_cnt,
    output logic [ChannelCount*16-1:0]        stat_up_cnt,
    output logic [15:0]                       stat_drop_cnt
`endif
);

    // state   | meaning
    // ST_IDLE | output register empty, waiting for any upstream FIFO to fill
    // ST_HOLD | output register valid; loads the next granted head on each accepted transfer
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam int AW   = $clog2(FifoDepth);
    localparam int PtrW = AW + 1;

    logic [ChannelCount-1:0] down_empty;
    logic [ChannelCount-1:0] down_full;
    logic [ChannelCount-1:0] up_empty;
    logic [ChannelCount-1:0] up_full;
    logic [ChannelCount-1:0] up_pop;
    logic [DataWidth-1:0]    up_head [ChannelCount];

    logic       chan_ok;
    logic       sel_full;
    state_t     state, state_nxt;
    logic       load;
    logic       any_up;
    logic [ChanW-1:0] rr_ptr;
    logic [ChanW-1:0] grant;

    assign chan_ok = (int'(host_tx_channel) < ChannelCount);

    always_comb begin
        sel_full = 1'b0;
        for (int i = 0; i < ChannelCount; i++) begin
            if (host_tx_channel == ChanW'(i)) sel_full = down_full[i];
        end
    end

    // Invalid channels are always accepted so a bad tag can never stall the host.
    assign host_tx_ready = !chan_ok || !sel_full;

    always_ff @(posedge clk) begin
        if (rst) bad_channel <= 1'b0;
        else     bad_channel <= host_tx_valid && !chan_ok;
    end

    for (genvar c = 0; c < ChannelCount; c++) begin : g_down
        logic [DataWidth-1:0] mem [FifoDepth];
        logic [PtrW-1:0]      wr_ptr;
        logic [PtrW-1:0]      rd_ptr;
        logic                 push;
        logic                 pop;

        assign push = host_tx_valid && host_tx_ready && chan_ok && (host_tx_channel == ChanW'(c));
        assign pop  = dut_rx_ready[c] && !down_empty[c];

        assign down_empty[c] = (wr_ptr == rd_ptr);
        assign down_full[c]  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PtrW'(1);
                if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (push) mem[wr_ptr[AW-1:0]] <= host_tx_data;
        end

        assign dut_rx_valid[c]                         = !down_empty[c];
        assign dut_rx_data[c*DataWidth +: DataWidth]   = mem[rd_ptr[AW-1:0]];
    end

    for (genvar c = 0; c < ChannelCount; c++) begin : g_up
        logic [DataWidth-1:0] mem [FifoDepth];
        logic [PtrW-1:0]      wr_ptr;
        logic [PtrW-1:0]      rd_ptr;
        logic                 push;

        assign push = dut_tx_valid[c] && !up_full[c];

        assign up_empty[c] = (wr_ptr == rd_ptr);
        assign up_full[c]  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push)      wr_ptr <= wr_ptr + PtrW'(1);
                if (up_pop[c]) rd_ptr <= rd_ptr + PtrW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (push) mem[wr_ptr[AW-1:0]] <= dut_tx_data[c*DataWidth +: DataWidth];
        end

        assign dut_tx_ready[c] = !up_full[c];
        assign up_head[c]      = mem[rd_ptr[AW-1:0]];
    end

    assign any_up = |(~up_empty);

    // First non-empty channel at or above the round-robin pointer, wrapping.
    always_comb begin
        int  idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < ChannelCount; i++) begin
            idx = (int'(rr_ptr) + i) % ChannelCount;
            if (!found && !up_empty[idx]) begin
                found = 1'b1;
                grant = ChanW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (any_up) begin
                    load      = 1'b1;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (host_rx_ready) begin
                    if (any_up) load      = 1'b1;
                    else        state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        up_pop = '0;
        if (load) up_pop[grant] = 1'b1;
    end

    assign host_rx_valid = (state == ST_HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            host_rx_channel <= '0;
            host_rx_data    <= '0;
            rr_ptr          <= '0;
        end else if (load) begin
            host_rx_channel <= grant;
            host_rx_data    <= up_head[grant];
            rr_ptr          <= ChanW'((int'(grant) + 1) % ChannelCount);
        end
    end

`ifdef RENODE_UART_BRIDGE_STATS_EN
    for (genvar c = 0; c < ChannelCount; c++) begin : g_stat
        logic [15:0] down_cnt;
        logic [15:0] up_cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                down_cnt <= '0;
                up_cnt   <= '0;
            end else begin
                if (dut_rx_ready[c] && dut_rx_valid[c] && down_cnt != 16'hFFFF)
                    down_cnt <= down_cnt + 16'd1;
                if (host_rx_valid && host_rx_ready && host_rx_channel == ChanW'(c) && up_cnt != 16'hFFFF)
                    up_cnt <= up_cnt + 16'd1;
            end
        end

        assign stat_down_cnt[c*16 +: 16] = down_cnt;
        assign stat_up_cnt[c*16 +: 16]   = up_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst)
            stat_drop_cnt <= '0;
        else if (host_tx_valid && !chan_ok && stat_drop_cnt != 16'hFFFF)
            stat_drop_cnt <= stat_drop_cnt + 16'd1;
    end
`endif

endmodule
